// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage MIPS pipeline.
//
// This block merges four hazard sources into per-stage-register enables and
// flushes. The sources are:
//   - load-use stall reported by the ID forwarding unit;
//   - HI/LO occupancy while a MULT/DIV is still in flight;
//   - exception/redirect flush;
//   - halt.
// It also sequences the multiply/divide unit with a down-counter.
//
// Priority, highest first:
//   rst > HALT state > halt_req > exc_flush > front_stall > normal flow.
//
// Optional build feature:
//   PIPE_PERF_CNT_EN - when defined, stall_cycles counts front-end stall
//   cycles. It counts only cycles where the pipeline is not halting. When
//   undefined, stall_cycles is tied to zero and no counter flops exist.
//
// Handshake-free block: every control is a level that is valid in the same
// cycle as its inputs. The one exception is mdu_start, a registered
// single-cycle pulse. It is high in the first cycle the MDU op sits in EXE.

module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,   // EXE occupancy of MULT/MULTU, 1..2^CNT_W
  parameter int DIV_CYCLES = 33,  // EXE occupancy of DIV/DIVU, 1..2^CNT_W
  parameter int CNT_W      = 6    // busy counter width
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_load_use,
  input  logic        id_is_mdu,
  input  logic        id_is_div,
  input  logic        id_reads_hilo,
  input  logic        exc_flush,
  input  logic        halt_req,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        id_exe_ena,
  output logic        exe_mem_ena,
  output logic        mem_wb_ena,
  output logic        if_id_flush,
  output logic        id_exe_flush,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // The counter is loaded with occupancy-1 so that "cnt==0" marks the last
  // busy cycle. An occupancy of 1 therefore gives exactly one MDU_BUSY cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdu_start_q, mdu_start_d;

  logic             hilo_haz;
  logic             front_stall;
  logic             halting;
  logic             issue;

  // Hazard decode shared by the next-state and output processes.
  always_comb begin
    mdu_busy    = (state_q == ST_MDU_BUSY);
    hilo_haz    = mdu_busy & (id_is_mdu | id_reads_hilo);
    front_stall = id_load_use | hilo_haz;
    halting     = (state_q == ST_HALT) | halt_req;
    // A new MDU op can only leave ID when the unit is idle and nothing
    // of higher priority is holding or squashing the front end.
    issue       = (state_q == ST_RUN) & id_is_mdu & ~halt_req & ~exc_flush &
                  ~front_stall;
  end

  // State, busy counter and start pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      mdu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_start_q <= mdu_start_d;
    end
  end

  // Next-state logic. In HALT the counter freezes, and only rst leaves it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdu_start_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (issue) begin
          state_d     = ST_MDU_BUSY;
          cnt_d       = id_is_div ? DIV_LOAD : MUL_LOAD;
          mdu_start_d = 1'b1;
        end
      end
      ST_MDU_BUSY: begin
        // A flush does not abort the count. The issued op still completes.
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: enables and flushes by priority.
  always_comb begin
    pc_ena       = 1'b1;
    if_id_ena    = 1'b1;
    id_exe_ena   = 1'b1;
    exe_mem_ena  = 1'b1;
    mem_wb_ena   = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    if (halting) begin
      pc_ena      = 1'b0;
      if_id_ena   = 1'b0;
      id_exe_ena  = 1'b0;
      exe_mem_ena = 1'b0;
      mem_wb_ena  = 1'b0;
    end else if (exc_flush) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (front_stall) begin
      // Hold PC and IF/ID. Push a bubble into EXE so the back end drains.
      pc_ena       = 1'b0;
      if_id_ena    = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

  assign mdu_start = mdu_start_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Count front-end stall cycles. Halt-induced freezes are not counted.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_ena && (state_q != ST_HALT) && !halt_req) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Performance counter register. It wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'h0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Merges hazard requests into per-stage-register enable and flush controls:
  - load-use stall from the ID forwarding unit;
  - multi-cycle MULT/DIV occupancy of HI/LO;
  - exception/branch flush;
  - halt.
- Sequences the multiply/divide unit with an internal busy counter. Sits beside the ID-stage forwarding logic and drives PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

Parameters:
- MUL_CYCLES, 4, EXE occupancy in cycles of MULT/MULTU (1..2^CNT_W).
- DIV_CYCLES, 33, EXE occupancy in cycles of DIV/DIVU (1..2^CNT_W).
- CNT_W, 6, busy counter width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- id_load_use  in  1  forwarding unit: ID operand depends on a load in EXE.
- id_is_mdu  in  1  ID holds MULT/MULTU/DIV/DIVU.
- id_is_div  in  1  ID MDU op is DIV/DIVU (valid with id_is_mdu).
- id_reads_hilo  in  1  ID holds MFHI/MFLO.
- exc_flush  in  1  squash IF/ID and ID/EXE contents (exception or redirect).
- halt_req  in  1  BREAK/SYSCALL-halt reached MEM.
- pc_ena  out  1  PC update enable.
- if_id_ena  out  1  IF/ID register enable.
- id_exe_ena  out  1  ID/EXE register enable.
- exe_mem_ena  out  1  EXE/MEM register enable.
- mem_wb_ena  out  1  MEM/WB register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_exe_flush  out  1  load bubble into ID/EXE.
- mdu_start  out  1  one-cycle registered pulse: MDU op entered EXE.
- mdu_busy  out  1  MDU occupied.
- stall_cycles  out  32  performance counter (optional feature).

Behaviour:
- State encoding: RUN=0, MDU_BUSY=1, HALT=2 (2-bit register).
- Busy counter: cnt, CNT_W bits.
- Reset values (asynchronous): state=RUN, cnt=0, mdu_start=0, stall_cycles=0.
- Combinational outputs after reset with all inputs 0: all *_ena=1, flushes=0, mdu_busy=0.
- Enables and flushes are combinational from state and inputs. mdu_start, cnt, state and stall_cycles are registered.
- mdu_busy = (state==MDU_BUSY).
- Hazard conditions:
  - hilo_haz = mdu_busy & (id_is_mdu | id_reads_hilo).
  - front_stall = id_load_use | hilo_haz.
- Priority, highest first: rst > HALT state > halt_req > exc_flush > front_stall > normal.
- HALT state, or halt_req=1: all five *_ena=0, flushes=0.
  - halt_req moves RUN/MDU_BUSY to HALT at the next edge.
  - HALT is left only by rst. cnt freezes.
- exc_flush (not halting): all *_ena=1, if_id_flush=1, id_exe_flush=1; front_stall ignored; no MDU issue this cycle.
- front_stall (no flush/halt):
  - pc_ena=0, if_id_ena=0, id_exe_ena=1, id_exe_flush=1 (bubble).
  - exe_mem_ena=mem_wb_ena=1.
- Issue: in RUN with id_is_mdu=1 and no flush/halt/front_stall, the op advances to EXE. At that edge:
  - state<=MDU_BUSY;
  - cnt<=(id_is_div ? DIV_CYCLES : MUL_CYCLES)-1;
  - mdu_start<=1 for exactly one cycle.
- MDU_BUSY:
  - cnt>0: cnt decrements each cycle.
  - cnt==0: state<=RUN at the next edge.
  - hilo_haz still asserts in the cnt==0 cycle; the dependent op issues the cycle after.
  - Independent instructions flow normally while busy.
- Parameter value 1: MDU_BUSY lasts exactly one cycle.
- exc_flush during MDU_BUSY does not abort the count; the issued op completes architecturally.
- Simultaneous id_load_use and hilo_haz: single stall, same outputs.
- rst mid-count: immediate return to RUN, cnt=0, mdu_start=0.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cycles increments by 1 on each edge where pc_ena==0 and state!=HALT and halt_req==0. Wraps 0xFFFFFFFF->0. Reset 0.
- Undefined: stall_cycles tied to 32'h0; no counter flops.

Test Plan:
- Reset, then all inputs 0 -> all *_ena=1, flushes=0, mdu_busy=0, mdu_start=0; rst pulse mid-DIV -> mdu_busy=0 immediately.
- MULT issued in RUN -> mdu_start high 1 cycle; mdu_busy high exactly 4 cycles. MFHI in ID during those cycles -> pc_ena=0, id_exe_flush=1 for 4 cycles; MFHI issues on the 5th.
- DIV issued, then independent ADDU stream -> no stalls; mdu_busy high 33 cycles; second DIV in ID at cycle 10 -> stalls until cycle 33, issues at 34 with a new mdu_start.
- id_load_use=1 and exc_flush=1 same cycle -> if_id_flush=1, id_exe_flush=1, pc_ena=1; next cycle id_load_use only -> pc_ena=0, if_id_ena=0, id_exe_flush=1.
- halt_req during MDU_BUSY (cnt=20) -> all enables 0 that cycle and forever after; cnt stays 20 until rst.
- PIPE_PERF_CNT_EN defined: 3 load-use cycles + 4 MFHI stall cycles -> stall_cycles=7; preload 0xFFFFFFFF + 1 stall -> 0.
